// File: rtl/ucsbece154_fetchq.sv
// Dual-issue instruction fetch queue. Each cycle it fetches two sequential words
// into a circular buffer, and decode pops up to two entries from its head.
module ucsbece154_fetchq #(
    parameter logic [31:0] TEXT_START = 32'h00010000,
    parameter int unsigned QDEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,

    output logic [31:0]              imem_a1_o,
    output logic [31:0]              imem_a2_o,
    input  logic [31:0]              imem_rd1_i,
    input  logic [31:0]              imem_rd2_i,

    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    input  logic [1:0]               deq_i,

    output logic                     valid1_o,
    output logic [31:0]              instr1_o,
    output logic [31:0]              pc1_o,
    output logic                     valid2_o,
    output logic [31:0]              instr2_o,
    output logic [31:0]              pc2_o,
    output logic [$clog2(QDEPTH):0]  count_o
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    localparam cnt_t DEPTH_C = cnt_t'(QDEPTH);
    localparam cnt_t TWO_C   = cnt_t'(2);

    entry_t      queue_q [QDEPTH];

    logic [31:0] pc_q,    pc_d;
    ptr_t        head_q,  head_d;
    ptr_t        tail_q,  tail_d;
    cnt_t        count_q, count_d;

    cnt_t        free_slots;
    cnt_t        deq_req;
    cnt_t        deq_eff;
    logic        enq;
    ptr_t        head_p1;
    ptr_t        tail_p1;

    // The two low bits of a redirect target are forced to zero.
    logic        unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    assign head_p1 = head_q + ptr_t'(1);
    assign tail_p1 = tail_q + ptr_t'(1);

    // Space is judged on the pre-edge count, so a same-cycle dequeue never
    // makes room for that cycle's pair.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        free_slots = DEPTH_C - count_q;
        enq        = !redirect_i && (free_slots >= TWO_C);
        deq_req    = (deq_i == 2'd3) ? TWO_C : cnt_t'(deq_i);
        deq_eff    = (deq_req > count_q) ? count_q : deq_req;

        pc_d       = pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (redirect_i) begin
            pc_d    = {redirect_pc_i[31:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + ptr_t'(deq_eff);
            count_d = count_q - deq_eff;
            if (enq) begin
                pc_d    = pc_q + 32'd8;
                tail_d  = tail_q + ptr_t'(2);
                count_d = count_q + TWO_C - deq_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            pc_q    <= TEXT_START;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry storage is deliberately not reset; contents are only
    // observed through valid1_o/valid2_o, which the cleared count gates.
    always_ff @(posedge clk) begin
        if (enq) begin
            queue_q[tail_q]  <= '{instr: imem_rd1_i, pc: pc_q};
            queue_q[tail_p1] <= '{instr: imem_rd2_i, pc: pc_q + 32'd4};
        end
    end

    assign imem_a1_o = pc_q;
    assign imem_a2_o = pc_q + 32'd4;

    assign valid1_o  = (count_q >= cnt_t'(1));
    assign valid2_o  = (count_q >= TWO_C);
    assign instr1_o  = queue_q[head_q].instr;
    assign pc1_o     = queue_q[head_q].pc;
    assign instr2_o  = queue_q[head_p1].instr;
    assign pc2_o     = queue_q[head_p1].pc;
    assign count_o   = count_q;

endmodule

// File: tb/tb_ucsbece154_fetchq.sv
// Directed and model-checked bench for the fetch queue; a second QDEPTH=4
// instance reaches the odd low occupancies that depth 8 cannot.
module tb_ucsbece154_fetchq;

    localparam logic [31:0] TS = 32'h00010000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  deq;

    logic [31:0] d8_a1, d8_a2, d8_i1, d8_i2, d8_p1, d8_p2;
    logic        d8_v1, d8_v2;
    logic [3:0]  d8_count;

    logic [31:0] d4_a1, d4_a2, d4_i1, d4_i2, d4_p1, d4_p2;
    logic        d4_v1, d4_v2;
    logic [2:0]  d4_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ucsbece154_fetchq #(.TEXT_START(TS), .QDEPTH(8)) u_dut8 (
        .clk(clk), .reset(reset),
        .imem_a1_o(d8_a1), .imem_a2_o(d8_a2),
        .imem_rd1_i(d8_a1), .imem_rd2_i(d8_a2),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc), .deq_i(deq),
        .valid1_o(d8_v1), .instr1_o(d8_i1), .pc1_o(d8_p1),
        .valid2_o(d8_v2), .instr2_o(d8_i2), .pc2_o(d8_p2),
        .count_o(d8_count)
    );

    ucsbece154_fetchq #(.TEXT_START(TS), .QDEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .imem_a1_o(d4_a1), .imem_a2_o(d4_a2),
        .imem_rd1_i(d4_a1), .imem_rd2_i(d4_a2),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc), .deq_i(deq),
        .valid1_o(d4_v1), .instr1_o(d4_i1), .pc1_o(d4_p1),
        .valid2_o(d4_v2), .instr2_o(d4_i2), .pc2_o(d4_p2),
        .count_o(d4_count)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; deq = 2'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h00000123; deq = 2'd2;
        tick();
        checks++; if (d8_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", d8_count); end
        checks++; if (d8_v1 !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %b exp 0", d8_v1); end
        checks++; if (d8_v2 !== 1'b0) begin errors++; $display("FAIL reset_valid2 got %b exp 0", d8_v2); end
        checks++; if (d8_a1 !== TS) begin errors++; $display("FAIL reset_a1 got %h exp %h", d8_a1, TS); end
        checks++; if (d8_a2 !== TS + 32'd4) begin errors++; $display("FAIL reset_a2 got %h exp %h", d8_a2, TS + 32'd4); end
        reset = 1'b0; redirect = 1'b0; deq = 2'd0;
    endtask

    task automatic test_fill();
        logic [3:0] exp_cnt [5] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd8};
        do_reset();
        deq = 2'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (d8_count !== exp_cnt[i]) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, d8_count, exp_cnt[i]); end
        end
        checks++; if (d8_a1 !== 32'h00010020) begin errors++; $display("FAIL fill_pc got %h exp 00010020", d8_a1); end
        checks++; if (d8_p1 !== 32'h00010000) begin errors++; $display("FAIL fill_pc1 got %h exp 00010000", d8_p1); end
        checks++; if (d8_i1 !== 32'h00010000) begin errors++; $display("FAIL fill_instr1 got %h exp 00010000", d8_i1); end
        checks++; if (d8_p2 !== 32'h00010004) begin errors++; $display("FAIL fill_pc2 got %h exp 00010004", d8_p2); end
        checks++; if (d8_i2 !== 32'h00010004) begin errors++; $display("FAIL fill_instr2 got %h exp 00010004", d8_i2); end
        checks++; if ({d8_v1, d8_v2} !== 2'b11) begin errors++; $display("FAIL fill_valid got %b exp 11", {d8_v1, d8_v2}); end
    endtask

    // Continues from the full queue left by test_fill.
    task automatic test_full_drain();
        deq = 2'd1;
        tick();
        checks++; if (d8_count !== 4'd7) begin errors++; $display("FAIL full_deq1_count got %0d exp 7", d8_count); end
        checks++; if (d8_p1 !== 32'h00010004) begin errors++; $display("FAIL full_deq1_pc1 got %h exp 00010004", d8_p1); end
        checks++; if (d8_a1 !== 32'h00010020) begin errors++; $display("FAIL full_deq1_pc got %h exp 00010020", d8_a1); end
        deq = 2'd0;
        tick();
        checks++; if (d8_count !== 4'd7) begin errors++; $display("FAIL full_stall_count got %0d exp 7", d8_count); end
        checks++; if (d8_a1 !== 32'h00010020) begin errors++; $display("FAIL full_stall_pc got %h exp 00010020", d8_a1); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        deq = 2'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (d8_count !== 4'd2) begin errors++; $display("FAIL b2b_count[%0d] got %0d exp 2", i, d8_count); end
            checks++; if (d8_p1 !== TS + 32'(8 * i)) begin errors++; $display("FAIL b2b_pc1[%0d] got %h exp %h", i, d8_p1, TS + 32'(8 * i)); end
            checks++; if (d8_p2 !== TS + 32'(8 * i + 4)) begin errors++; $display("FAIL b2b_pc2[%0d] got %h exp %h", i, d8_p2, TS + 32'(8 * i + 4)); end
        end
        deq = 2'd0;
    endtask

    task automatic test_redirect();
        do_reset();
        deq = 2'd0;
        repeat (3) tick();
        checks++; if (d8_count !== 4'd6) begin errors++; $display("FAIL redir_pre_count got %0d exp 6", d8_count); end
        redirect = 1'b1; redirect_pc = 32'h00010047; deq = 2'd2;
        tick();
        checks++; if (d8_count !== 4'd0) begin errors++; $display("FAIL redir_count got %0d exp 0", d8_count); end
        checks++; if ({d8_v1, d8_v2} !== 2'b00) begin errors++; $display("FAIL redir_valid got %b exp 00", {d8_v1, d8_v2}); end
        checks++; if (d8_a1 !== 32'h00010044) begin errors++; $display("FAIL redir_a1 got %h exp 00010044", d8_a1); end
        checks++; if (d8_a2 !== 32'h00010048) begin errors++; $display("FAIL redir_a2 got %h exp 00010048", d8_a2); end
        redirect = 1'b0; deq = 2'd0;
        tick();
        checks++; if (d8_count !== 4'd2) begin errors++; $display("FAIL redir_post_count got %0d exp 2", d8_count); end
        checks++; if (d8_p1 !== 32'h00010044) begin errors++; $display("FAIL redir_pc1 got %h exp 00010044", d8_p1); end
        checks++; if (d8_p2 !== 32'h00010048) begin errors++; $display("FAIL redir_pc2 got %h exp 00010048", d8_p2); end
        checks++; if (d8_i1 !== 32'h00010044) begin errors++; $display("FAIL redir_instr1 got %h exp 00010044", d8_i1); end
    endtask

    task automatic test_reset_priority();
        do_reset();
        deq = 2'd0;
        repeat (4) tick();
        checks++; if (d8_count !== 4'd8) begin errors++; $display("FAIL rstpri_pre_count got %0d exp 8", d8_count); end
        reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h00020000; deq = 2'd2;
        tick();
        checks++; if (d8_count !== 4'd0) begin errors++; $display("FAIL rstpri_count got %0d exp 0", d8_count); end
        checks++; if (d8_v1 !== 1'b0) begin errors++; $display("FAIL rstpri_valid1 got %b exp 0", d8_v1); end
        checks++; if (d8_a1 !== TS) begin errors++; $display("FAIL rstpri_a1 got %h exp %h", d8_a1, TS); end
        reset = 1'b0; redirect = 1'b0; deq = 2'd0;
    endtask

    // Depth-4 instance: walk down to count 1, then over-request dequeues.
    task automatic test_clamp();
        do_reset();
        deq = 2'd0;
        repeat (2) tick();
        checks++; if (d4_count !== 3'd4) begin errors++; $display("FAIL clamp_full got %0d exp 4", d4_count); end
        deq = 2'd1;
        tick();
        checks++; if (d4_count !== 3'd3) begin errors++; $display("FAIL clamp_3 got %0d exp 3", d4_count); end
        deq = 2'd2;
        tick();
        checks++; if (d4_count !== 3'd1) begin errors++; $display("FAIL clamp_1 got %0d exp 1", d4_count); end
        checks++; if (d4_p1 !== 32'h0001000c) begin errors++; $display("FAIL clamp_1_pc1 got %h exp 0001000c", d4_p1); end
        checks++; if ({d4_v1, d4_v2} !== 2'b10) begin errors++; $display("FAIL clamp_1_valid got %b exp 10", {d4_v1, d4_v2}); end
        tick();
        checks++; if (d4_count !== 3'd2) begin errors++; $display("FAIL clamp_under got %0d exp 2", d4_count); end
        checks++; if (d4_p1 !== 32'h00010010) begin errors++; $display("FAIL clamp_under_pc1 got %h exp 00010010", d4_p1); end
        checks++; if (d4_p2 !== 32'h00010014) begin errors++; $display("FAIL clamp_under_pc2 got %h exp 00010014", d4_p2); end
        deq = 2'd3;
        tick();
        checks++; if (d4_count !== 3'd2) begin errors++; $display("FAIL clamp_deq3 got %0d exp 2", d4_count); end
        checks++; if (d4_p1 !== 32'h00010018) begin errors++; $display("FAIL clamp_deq3_pc1 got %h exp 00010018", d4_p1); end
        deq = 2'd0;
    endtask

    task automatic test_random();
        logic [31:0] mq[$];
        logic [31:0] mpc;
        int          n, dreq, d;
        do_reset();
        mpc = TS;
        for (int cyc = 0; cyc < 40; cyc++) begin
            deq         = 2'($urandom_range(0, 3));
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom;
            n = mq.size();
            if (redirect) begin
                mq.delete();
                mpc = {redirect_pc[31:2], 2'b00};
            end else begin
                dreq = (deq == 2'd3) ? 2 : int'(deq);
                d    = (dreq > n) ? n : dreq;
                repeat (d) void'(mq.pop_front());
                if (8 - n >= 2) begin
                    mq.push_back(mpc);
                    mq.push_back(mpc + 32'd4);
                    mpc = mpc + 32'd8;
                end
            end
            tick();
            checks++; if (d8_count !== 4'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", cyc, d8_count, mq.size()); end
            checks++; if (d8_a1 !== mpc) begin errors++; $display("FAIL rnd_pc[%0d] got %h exp %h", cyc, d8_a1, mpc); end
            if (mq.size() >= 1) begin
                checks++; if (d8_p1 !== mq[0] || d8_i1 !== mq[0]) begin errors++; $display("FAIL rnd_head[%0d] got pc %h instr %h exp %h", cyc, d8_p1, d8_i1, mq[0]); end
            end
            if (mq.size() >= 2) begin
                checks++; if (d8_p2 !== mq[1]) begin errors++; $display("FAIL rnd_pc2[%0d] got %h exp %h", cyc, d8_p2, mq[1]); end
            end
        end
        redirect = 1'b0; deq = 2'd0;
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; deq = 2'd0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_full_drain();
        test_back_to_back();
        test_redirect();
        test_reset_priority();
        test_clamp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
